// File: rtl/rom_reset_sequencer_pkg.sv
// Shared definitions for the reset-sequence ROM reader: state encoding,
// instruction width and the default sequence length of the reset ROM.
package rom_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam int          INST_W            = 19;
    localparam logic [18:0] NOP_WORD          = 19'h7f000;
    localparam int          DEFAULT_LAST_ADDR = 2;

endpackage

// File: rtl/rom_reset_sequencer.sv
// Walks the reset ROM from address 0 to LAST_ADDR and hands each word to the
// core over valid/ready, holding off normal fetch until the sequence ends.
//
// state | meaning
// FETCH | capture rom_dout at rom_addr into inst, raise inst_valid
// ISSUE | present inst until the core accepts it
// DONE  | sequence complete, core released; wait for start to re-run
module rom_reset_sequencer
    import rom_reset_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = INST_W,
    parameter int LAST_ADDR = DEFAULT_LAST_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              core_hold,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    seq_state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            rom_addr   <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    inst       <= rom_dout;
                    inst_valid <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    // start is deliberately not looked at here; it only counts in DONE
                    if (inst_valid && inst_ready) begin
                        inst_valid <= 1'b0;
                        if (rom_addr == LAST) begin
                            core_hold <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        rom_addr  <= '0;
                        done      <= 1'b0;
                        core_hold <= 1'b1;
                        state     <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_reset_sequencer.sv
// Self-checking bench for rom_reset_sequencer: a 3-word instance and an
// 8-word instance, checked cycle by cycle against a handshake timeline model.
module tb_rom_reset_sequencer;
    import rom_reset_sequencer_pkg::*;

    localparam int LAST_A = 2;
    localparam int LAST_B = 7;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1, reset_b = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        ready_a = 1'b0, ready_b = 1'b0;
    logic [2:0]  addr_a, addr_b;
    logic [18:0] dout_a, dout_b, inst_a, inst_b;
    logic        valid_a, valid_b, hold_a, hold_b, done_a, done_b;

    logic [18:0] rom_a  [8];
    logic [18:0] want_a [8];
    logic [18:0] rom_b  [8];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign dout_a = rom_a[addr_a];
    assign dout_b = rom_b[addr_b];

    rom_reset_sequencer #(.ADDR_W(3), .DATA_W(19), .LAST_ADDR(LAST_A)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .rom_addr(addr_a),
        .rom_dout(dout_a), .inst(inst_a), .inst_valid(valid_a),
        .inst_ready(ready_a), .core_hold(hold_a), .done(done_a)
    );

    rom_reset_sequencer #(.ADDR_W(3), .DATA_W(19), .LAST_ADDR(LAST_B)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .rom_addr(addr_b),
        .rom_dout(dout_b), .inst(inst_b), .inst_valid(valid_b),
        .inst_ready(ready_b), .core_hold(hold_b), .done(done_b)
    );

    task automatic load_rom_a(input bit randomize);
        for (int i = 0; i < 8; i++) begin
            if (randomize) want_a[i] = 19'($urandom);
            else           want_a[i] = 19'($urandom);
        end
        if (!randomize) begin
            want_a[0] = NOP_WORD;
            want_a[1] = 19'h74000;
            want_a[2] = NOP_WORD;
        end
        for (int i = 0; i < 8; i++) rom_a[i] = want_a[i];
    endtask

    task automatic test_reset;
        reset_a = 1'b1; start_a = 1'b0; ready_a = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid_a, hold_a, done_a, addr_a, inst_a} !== {1'b0, 1'b1, 1'b0, 3'd0, 19'd0}) begin
            failures++;
            $display("FAIL reset_values got v=%0b h=%0b d=%0b a=%0d i=%h want v=0 h=1 d=0 a=0 i=00000",
                     valid_a, hold_a, done_a, addr_a, inst_a);
        end
        reset_a = 1'b0;
    endtask

    // Model: word k becomes valid at cycle vstart, is accepted on the first
    // cycle ready is high, and word k+1 is valid two cycles later.
    task automatic run_seq(input string name, input int vstart0, input int ready_pct,
                           input int stall_len, input bit start_in_issue,
                           output int done_at);
        int c = 0, idx = 0, vstart = vstart0, waited = 0, hs = 0;
        logic [18:0] exp_word = '0;
        bit rdy;
        done_at = -1;
        forever begin
            @(posedge clk);
            @(negedge clk);
            c++;
            start_a = 1'b0;
            if (c > 200) begin
                checks++; failures++;
                $display("FAIL %s_timeout got no completion within 200 cycles want done", name);
                break;
            end
            if (idx > LAST_A) begin
                checks++;
                if ({valid_a, hold_a, done_a, addr_a} !== {1'b1 ^ 1'b1, 1'b0, 1'b1, 3'(LAST_A)}) begin
                    failures++;
                    $display("FAIL %s_done c=%0d got v=%0b h=%0b d=%0b a=%0d want v=0 h=0 d=1 a=%0d",
                             name, c, valid_a, hold_a, done_a, addr_a, LAST_A);
                end
                ready_a = 1'($urandom);
                if (c >= done_at + 2) break;
            end else if (c >= vstart) begin
                if (c == vstart) begin
                    exp_word = want_a[idx];
                    waited = 0;
                end
                checks++;
                if ({valid_a, hold_a, done_a, addr_a} !== {1'b1, 1'b1, 1'b0, 3'(idx)}) begin
                    failures++;
                    $display("FAIL %s_issue c=%0d got v=%0b h=%0b d=%0b a=%0d want v=1 h=1 d=0 a=%0d",
                             name, c, valid_a, hold_a, done_a, addr_a, idx);
                end
                checks++;
                if (inst_a !== exp_word) begin
                    failures++;
                    $display("FAIL %s_inst c=%0d word=%0d got %h want %h", name, c, idx, inst_a, exp_word);
                end
                if (start_in_issue && idx == 0 && c == vstart) start_a = 1'b1;
                if (idx == 1 && waited < stall_len) rdy = 1'b0;
                else rdy = ($urandom_range(99) < ready_pct);
                ready_a = rdy;
                if (rdy) begin
                    rom_a[idx] = want_a[idx];
                    hs++;
                    idx++;
                    vstart = c + 2;
                    if (idx > LAST_A) done_at = c + 1;
                end else begin
                    // ROM changes while a word is presented must not reach inst
                    rom_a[idx] = 19'($urandom);
                    waited++;
                end
            end else begin
                checks++;
                if ({valid_a, hold_a, done_a, addr_a} !== {1'b0, 1'b1, 1'b0, 3'(idx)}) begin
                    failures++;
                    $display("FAIL %s_fetch c=%0d got v=%0b h=%0b d=%0b a=%0d want v=0 h=1 d=0 a=%0d",
                             name, c, valid_a, hold_a, done_a, addr_a, idx);
                end
                ready_a = 1'($urandom);
            end
        end
        checks++;
        if (hs != LAST_A + 1) begin
            failures++;
            $display("FAIL %s_handshakes got %0d want %0d", name, hs, LAST_A + 1);
        end
    endtask

    task automatic test_basic_sequence;
        int d;
        load_rom_a(1'b0);
        test_reset();
        run_seq("basic", 1, 100, 0, 1'b0, d);
        checks++;
        if (d != 6) begin
            failures++;
            $display("FAIL basic_done_cycle got %0d want 6", d);
        end
    endtask

    task automatic test_stall;
        int d;
        load_rom_a(1'b0);
        test_reset();
        run_seq("stall", 1, 100, 4, 1'b0, d);
        checks++;
        if (d != 10) begin
            failures++;
            $display("FAIL stall_done_cycle got %0d want 10", d);
        end
    endtask

    task automatic test_restart;
        int d;
        start_a = 1'b1;
        run_seq("restart", 2, 100, 0, 1'b0, d);
        checks++;
        if (d != 7) begin
            failures++;
            $display("FAIL restart_done_cycle got %0d want 7", d);
        end
    endtask

    task automatic test_start_in_issue;
        int d;
        load_rom_a(1'b1);
        test_reset();
        run_seq("start_ignored", 1, 60, 0, 1'b1, d);
    endtask

    task automatic test_random_ready;
        int d;
        for (int r = 0; r < 4; r++) begin
            load_rom_a(1'b1);
            test_reset();
            run_seq("random", 1, 40, int'($urandom_range(3)), 1'b0, d);
            start_a = 1'b1;
            run_seq("random_rerun", 2, 50, 0, 1'b0, d);
        end
    endtask

    task automatic test_async_reset;
        int n = 0, d;
        load_rom_a(1'b0);
        test_reset();
        ready_a = 1'b1;
        while (!(valid_a && addr_a == 3'd1) && n < 20) begin
            @(negedge clk);
            if (valid_a && addr_a == 3'd1) ready_a = 1'b0;
            n++;
        end
        ready_a = 1'b0;
        checks++;
        if (!(valid_a && addr_a == 3'd1)) begin
            failures++;
            $display("FAIL async_setup got v=%0b a=%0d want v=1 a=1", valid_a, addr_a);
        end
        @(negedge clk);
        #2 reset_a = 1'b1;
        #1;
        checks++;
        if ({valid_a, hold_a, done_a, addr_a, inst_a} !== {1'b0, 1'b1, 1'b0, 3'd0, 19'd0}) begin
            failures++;
            $display("FAIL async_reset got v=%0b h=%0b d=%0b a=%0d i=%h want v=0 h=1 d=0 a=0 i=00000",
                     valid_a, hold_a, done_a, addr_a, inst_a);
        end
        @(negedge clk);
        reset_a = 1'b0;
        run_seq("after_reset", 1, 100, 0, 1'b0, d);
    endtask

    task automatic test_full_rom;
        int c = 0, hs = 0;
        for (int i = 0; i < 8; i++) rom_b[i] = 19'(i);
        reset_b = 1'b1; ready_b = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
        while (!done_b && c < 40) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            if (valid_b) begin
                checks++;
                if (inst_b !== 19'(hs) || addr_b !== 3'(hs)) begin
                    failures++;
                    $display("FAIL full_word got i=%h a=%0d want i=%h a=%0d", inst_b, addr_b, 19'(hs), hs);
                end
                hs++;
            end
        end
        checks++;
        if (hs != LAST_B + 1 || c != 16) begin
            failures++;
            $display("FAIL full_count got hs=%0d cycle=%0d want hs=8 cycle=16", hs, c);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done_b, hold_b, valid_b, addr_b} !== {1'b1, 1'b0, 1'b0, 3'd7}) begin
            failures++;
            $display("FAIL full_no_wrap got d=%0b h=%0b v=%0b a=%0d want d=1 h=0 v=0 a=7",
                     done_b, hold_b, valid_b, addr_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rom_a[i] = '0; want_a[i] = '0; rom_b[i] = '0;
        end
        test_basic_sequence();
        test_restart();
        test_stall();
        test_start_in_issue();
        test_random_ready();
        test_async_reset();
        test_full_rom();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
